regfile_bist_ctrl: RTL

March C- memory BIST engine that drives the register-file test port (BIST enable, CSN_T/WEN_T/A_T/D_T, Q_T return) from the BIST-collar side. On a start pulse it takes the port and sweeps all writable words with six March elements. It compares read data one cycle after each read request and reports pass/fail, the first failing address and element, and a saturating error count. It sits beside the register-file test wrapper in the core and is triggered from the test/DFT controller.

---
 rtl/regfile_bist_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_bist_ctrl.sv
// March C- BIST engine driving the register-file test port (BIST, CSN_T, WEN_T, A_T, D_T, Q_T).
// Define REGFILE_BIST_CHKBD_EN to add a second pass with a 0x55../0xAA.. checkerboard background.
module regfile_bist_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 2**(ADDR_WIDTH-1)-1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
`ifdef REGFILE_BIST_CHKBD_EN
    output logic [3:0]            fail_elem_o,
`else
    output logic [2:0]            fail_elem_o,
`endif
    output logic [7:0]            err_cnt_o,
    output logic                  bist_o,
    output logic                  csn_t_o,
    output logic                  wen_t_o,
    output logic [ADDR_WIDTH-1:0] a_t_o,
    output logic [DATA_WIDTH-1:0] d_t_o,
    input  logic [DATA_WIDTH-1:0] q_t_i
);

    localparam int AW = ADDR_WIDTH - 1;
`ifdef REGFILE_BIST_CHKBD_EN
    localparam int EW = 4;
`else
    localparam int EW = 3;
`endif
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t                state, state_nx;
    logic [2:0]            elem, elem_nx;
    logic [AW-1:0]         addr, addr_nx;
    logic                  phase, phase_nx;   // 0: read slot, 1: write slot of r/w elements

    logic                  is_read, is_write, last_op, descending;
    logic [AW-1:0]         end_addr;
    logic [DATA_WIDTH-1:0] bg, rd_exp, wr_data;
    logic [EW-1:0]         elem_tag;

    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_exp;
    logic [ADDR_WIDTH-1:0] pipe_addr;
    logic [EW-1:0]         pipe_elem;
    logic                  mismatch;

`ifdef REGFILE_BIST_CHKBD_EN
    localparam logic [DATA_WIDTH-1:0] CHKBD = DATA_WIDTH'({((DATA_WIDTH+1)/2){2'b01}});
    logic pass, pass_nx;
    assign bg       = pass ? CHKBD : '0;
    assign elem_tag = {pass, elem};
`else
    assign bg       = '0;
    assign elem_tag = elem;
`endif

    // E1/E3 write ~B, E2/E4 read ~B; everything else uses B.
    assign rd_exp  = (elem == 3'd2 || elem == 3'd4) ? ~bg : bg;
    assign wr_data = (elem == 3'd1 || elem == 3'd3) ? ~bg : bg;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nx   = state;
        elem_nx    = elem;
        addr_nx    = addr;
        phase_nx   = phase;
`ifdef REGFILE_BIST_CHKBD_EN
        pass_nx    = pass;
`endif
        is_read    = 1'b0;
        is_write   = 1'b0;
        last_op    = 1'b0;
        descending = (elem == 3'd3 || elem == 3'd4);
        end_addr   = descending ? '0 : LAST_ADDR;

        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = RUN;
                    elem_nx  = 3'd0;
                    addr_nx  = '0;
                    phase_nx = 1'b0;
`ifdef REGFILE_BIST_CHKBD_EN
                    pass_nx  = 1'b0;
`endif
                end
            end
            RUN: begin
                is_read  = (elem == 3'd5) || (elem != 3'd0 && !phase);
                is_write = !is_read;
                last_op  = (elem == 3'd0) || (elem == 3'd5) || phase;
                if (!last_op) begin
                    phase_nx = 1'b1;
                end else begin
                    phase_nx = 1'b0;
                    if (addr != end_addr) begin
                        addr_nx = descending ? addr - 1'b1 : addr + 1'b1;
                    end else if (elem == 3'd5) begin
                        state_nx = CHECK;
                        addr_nx  = '0;
                    end else begin
                        // Elements 3 and 4 sweep downwards, so they start at the top word.
                        elem_nx = elem + 1'b1;
                        addr_nx = (elem == 3'd2 || elem == 3'd3) ? LAST_ADDR : '0;
                    end
                end
            end
            CHECK: begin
`ifdef REGFILE_BIST_CHKBD_EN
                if (!pass) begin
                    state_nx = RUN;
                    pass_nx  = 1'b1;
                    elem_nx  = 3'd0;
                    addr_nx  = '0;
                end else begin
                    state_nx = DONE;
                end
`else
                state_nx = DONE;
`endif
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mismatch = pipe_valid && (q_t_i != pipe_exp);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            state       <= IDLE;
            elem        <= 3'd0;
            addr        <= '0;
            phase       <= 1'b0;
`ifdef REGFILE_BIST_CHKBD_EN
            pass        <= 1'b0;
`endif
            pipe_valid  <= 1'b0;
            pipe_exp    <= '0;
            pipe_addr   <= '0;
            pipe_elem   <= '0;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= '0;
            err_cnt_o   <= 8'd0;
        end else begin
            state      <= state_nx;
            elem       <= elem_nx;
            addr       <= addr_nx;
            phase      <= phase_nx;
`ifdef REGFILE_BIST_CHKBD_EN
            pass       <= pass_nx;
`endif
            pipe_valid <= is_read;
            pipe_exp   <= rd_exp;
            pipe_addr  <= {1'b0, addr};
            pipe_elem  <= elem_tag;

            if (state == IDLE && start_i) begin
                fail_o      <= 1'b0;
                fail_addr_o <= '0;
                fail_elem_o <= '0;
                err_cnt_o   <= 8'd0;
            end else if (mismatch) begin
                fail_o <= 1'b1;
                if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                if (!fail_o) begin
                    fail_addr_o <= pipe_addr;
                    fail_elem_o <= pipe_elem;
                end
            end
        end
    end

    // Test-port and handshake outputs are plain decodes of registered state.
    assign busy_o  = (state == RUN) || (state == CHECK);
    assign done_o  = (state == DONE);
    assign bist_o  = (state == RUN) || (state == CHECK);
    assign csn_t_o = (state != RUN);
    assign wen_t_o = !is_write;
    assign a_t_o   = (state == RUN) ? {1'b0, addr} : '0;
    assign d_t_o   = is_write ? wr_data : '0;

endmodule
